// File: rtl/result_display.sv
// Display stage: BCD conversion of the accumulator result and 6-digit 7-segment scan.
// Optional LEADING_ZERO_BLANK_EN blanks leading zeros of the integer part.
module result_display #(
   parameter int REFRESH_DIV    = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] acc_int,
   input  logic [6:0] frac_q,
   input  logic       frac_err,
   output logic       busy,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

   localparam logic [3:0] G_BL = 4'd10;
   localparam logic [3:0] G_MI = 4'd11;
   localparam logic [3:0] G_E  = 4'd12;
   localparam logic [3:0] G_R  = 4'd13;

   localparam logic [5:0][3:0] RESET_DIG =
      {G_BL, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

   typedef enum logic [1:0] {
      IDLE,
      CONV_INT,
      CONV_FRAC,
      COMMIT
   } state_t;

   state_t state, state_nxt;

   logic [2:0]  cnt;
   logic [19:0] ish;
   logic [19:0] ish_adj;
   logic [14:0] fsh;
   logic [14:0] fsh_adj;
   logic        neg;
   logic        err;

   logic        pend;
   logic [7:0]  pend_acc;
   logic [6:0]  pend_frac;
   logic        pend_err;

   logic        start;
   logic [7:0]  src_acc;
   logic [6:0]  src_frac;
   logic        src_err;
   logic [7:0]  src_mag;
   logic [6:0]  src_fcl;

   logic [5:0][3:0] dig, dig_nxt, commit_dig;
   logic            errs, errs_nxt;
   logic [PW-1:0]   pre, pre_nxt;
   logic [2:0]      idx, idx_nxt;
   logic [6:0]      seg_nxt;
   logic [5:0]      an_nxt;
   logic            dp_nxt;
   logic [3:0]      d_h, d_t, d_u;

   function automatic logic [3:0] adj(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] font(input logic [3:0] g);
      case (g)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         G_MI:    return 7'h40;
         G_E:     return 7'h79;
         G_R:     return 7'h50;
         default: return 7'h00;
      endcase
   endfunction

   assign busy = (state != IDLE);

   // A pending value is consumed as soon as the FSM is back in IDLE.
   assign start    = (state == IDLE) && (load || pend);
   assign src_acc  = load ? acc_int  : pend_acc;
   assign src_frac = load ? frac_q   : pend_frac;
   assign src_err  = load ? frac_err : pend_err;
   assign src_mag  = src_acc[7] ? 8'd0 - src_acc : src_acc;
   assign src_fcl  = (src_frac > 7'd99) ? 7'd99 : src_frac;

   assign ish_adj = {adj(ish[19:16]), adj(ish[15:12]),
                     adj(ish[11:8]), ish[7:0]};
   assign fsh_adj = {adj(fsh[14:11]), adj(fsh[10:7]), fsh[6:0]};

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (start) state_nxt = src_err ? COMMIT : CONV_INT;
         CONV_INT:  if (cnt == 3'd7) state_nxt = CONV_FRAC;
         CONV_FRAC: if (cnt == 3'd6) state_nxt = COMMIT;
         COMMIT:    state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
      if (rst) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= 3'd0;
         ish       <= '0;
         fsh       <= '0;
         neg       <= 1'b0;
         err       <= 1'b0;
         pend      <= 1'b0;
         pend_acc  <= '0;
         pend_frac <= '0;
         pend_err  <= 1'b0;
      end else begin
         if (start) begin
            ish <= {12'd0, src_mag};
            fsh <= {8'd0, src_fcl};
            neg <= src_acc[7];
            err <= src_err;
            cnt <= 3'd0;
         end else if (state == CONV_INT) begin
            ish <= ish_adj << 1;
            cnt <= (cnt == 3'd7) ? 3'd0 : cnt + 3'd1;
         end else if (state == CONV_FRAC) begin
            fsh <= fsh_adj << 1;
            cnt <= cnt + 3'd1;
         end
         if (load && state != IDLE) begin
            pend      <= 1'b1;
            pend_acc  <= acc_int;
            pend_frac <= frac_q;
            pend_err  <= frac_err;
         end else if (start) begin
            pend <= 1'b0;
         end
      end
   end

   assign d_h = ish[19:16];
   assign d_t = ish[15:12];
   assign d_u = ish[11:8];

   always_comb begin
      if (err) begin
         commit_dig = {G_BL, G_E, G_R, G_R, G_BL, G_BL};
      end else begin
         commit_dig = {neg ? G_MI : G_BL, d_h, d_t, d_u,
                       fsh[14:11], fsh[10:7]};
`ifdef LEADING_ZERO_BLANK_EN
         if (d_h == 4'd0) commit_dig[4] = G_BL;
         if (d_h == 4'd0 && d_t == 4'd0) commit_dig[3] = G_BL;
`endif
      end
   end

   // Outputs are registered from next-state values so seg/dp track an.
   always_comb begin
      pre_nxt  = (pre == PRE_MAX) ? '0 : pre + 1'b1;
      idx_nxt  = idx;
      if (pre == PRE_MAX) idx_nxt = (idx == 3'd0) ? 3'd5 : idx - 3'd1;
      dig_nxt  = dig;
      errs_nxt = errs;
      if (state == COMMIT) begin
         dig_nxt  = commit_dig;
         errs_nxt = err;
      end
      if (rst) begin
         pre_nxt  = '0;
         idx_nxt  = 3'd0;
         dig_nxt  = RESET_DIG;
         errs_nxt = 1'b0;
      end
      seg_nxt = font(dig_nxt[idx_nxt]);
      an_nxt  = 6'b000001 << idx_nxt;
      dp_nxt  = (idx_nxt == 3'd2) && !errs_nxt;
      if (SEG_ACTIVE_LOW) begin
         seg_nxt = ~seg_nxt;
         an_nxt  = ~an_nxt;
         dp_nxt  = ~dp_nxt;
      end
   end

   always_ff @(posedge clk) begin
      pre  <= pre_nxt;
      idx  <= idx_nxt;
      dig  <= dig_nxt;
      errs <= errs_nxt;
      seg  <= seg_nxt;
      an   <= an_nxt;
      dp   <= dp_nxt;
   end

endmodule

// File: tb/tb_result_display.sv
// Bench for result_display: two instances (active-low and active-high outputs)
// checked against an arithmetic model of the displayed digits.
module tb_result_display;

   localparam int DIV = 4;
   localparam logic [3:0] GB = 4'd10;
   localparam logic [3:0] GM = 4'd11;
   localparam logic [3:0] GE = 4'd12;
   localparam logic [3:0] GR = 4'd13;
   localparam logic [5:0][3:0] RST_PAT = {GB, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

   logic       clk = 1'b0;
   logic       rst, load, frac_err;
   logic [7:0] acc_int;
   logic [6:0] frac_q;
   logic       busy_l, busy_h, dp_l, dp_h;
   logic [6:0] seg_l, seg_h;
   logic [5:0] an_l, an_h;

   int total = 0;
   int bad   = 0;

   logic [5:0][3:0] shown;
   logic [5:0][6:0] obs_seg_h, obs_seg_l;
   logic [5:0]      obs_dp_h, obs_dp_l, seen_h, seen_l;
   bit              an_ok;
   int              nh, nl;
   logic [6:0]      o16_seg, o17_seg;
   logic [5:0]      o16_an, o17_an;
   logic            o17_dp;

   result_display #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut_l (
      .clk(clk), .rst(rst), .load(load), .acc_int(acc_int),
      .frac_q(frac_q), .frac_err(frac_err), .busy(busy_l),
      .seg(seg_l), .dp(dp_l), .an(an_l));

   result_display #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b0)) dut_h (
      .clk(clk), .rst(rst), .load(load), .acc_int(acc_int),
      .frac_q(frac_q), .frac_err(frac_err), .busy(busy_h),
      .seg(seg_h), .dp(dp_h), .an(an_h));

   always #5 clk = ~clk;

   function automatic logic [6:0] font(input logic [3:0] g);
      case (g)
         4'd0: return 7'b0111111;
         4'd1: return 7'b0000110;
         4'd2: return 7'b1011011;
         4'd3: return 7'b1001111;
         4'd4: return 7'b1100110;
         4'd5: return 7'b1101101;
         4'd6: return 7'b1111101;
         4'd7: return 7'b0000111;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1101111;
         GM:   return 7'b1000000;
         GE:   return 7'b1111001;
         GR:   return 7'b1010000;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic [5:0][6:0] segs(input logic [5:0][3:0] g);
      logic [5:0][6:0] r;
      for (int i = 0; i < 6; i++) r[i] = font(g[i]);
      return r;
   endfunction

   function automatic logic [5:0][3:0] model(input logic [7:0] acc,
                                             input int frac,
                                             input bit err);
      logic [5:0][3:0] g;
      int v, m, fr;
      if (err) return {GB, GE, GR, GR, GB, GB};
      v  = $signed(acc);
      m  = (v < 0) ? -v : v;
      fr = (frac > 99) ? 99 : frac;
      g[5] = (v < 0) ? GM : GB;
      g[4] = 4'(m / 100);
      g[3] = 4'((m / 10) % 10);
      g[2] = 4'(m % 10);
      g[1] = 4'(fr / 10);
      g[0] = 4'(fr % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (m < 100) g[4] = GB;
      if (m < 10) g[3] = GB;
`endif
      return g;
   endfunction

   function automatic int slot(input logic [5:0] a);
      int s;
      s = -1;
      for (int i = 0; i < 6; i++) if (a[i]) s = i;
      return $onehot(a) ? s : -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic read_display();
      obs_seg_h = '0; obs_seg_l = '0;
      obs_dp_h = '0; obs_dp_l = '0;
      seen_h = '0; seen_l = '0;
      an_ok = 1'b1;
      for (int c = 0; c < 6 * DIV; c++) begin
         if (!$onehot(an_h) || !$onehot(~an_l)) an_ok = 1'b0;
         for (int i = 0; i < 6; i++) begin
            if (an_h[i]) begin
               obs_seg_h[i] = seg_h; obs_dp_h[i] = dp_h; seen_h[i] = 1'b1;
            end
            if (!an_l[i]) begin
               obs_seg_l[i] = seg_l; obs_dp_l[i] = dp_l; seen_l[i] = 1'b1;
            end
         end
         step();
      end
   endtask

   task automatic run_load(input logic [7:0] a, input int f, input bit e);
      int n;
      acc_int = a; frac_q = 7'(f); frac_err = e; load = 1'b1;
      step();
      load = 1'b0;
      n = 0; nh = 0; nl = 0; o16_an = '0; o16_seg = '0;
      while ((busy_h || busy_l) && n < 40) begin
         if (busy_h) nh++;
         if (busy_l) nl++;
         o16_seg = seg_h; o16_an = an_h;
         step();
         n++;
      end
      o17_seg = seg_h; o17_an = an_h; o17_dp = dp_h;
   endtask

   task automatic test_reset();
      total++;
      if (busy_h !== 1'b0 || busy_l !== 1'b0) begin
         bad++;
         $display("FAIL reset_busy got=%b/%b want=0", busy_h, busy_l);
      end
      total++;
      if (an_h !== 6'b000001 || an_l !== 6'b111110) begin
         bad++;
         $display("FAIL reset_an got=%b/%b want=000001/111110", an_h, an_l);
      end
      total++;
      if (seg_h !== font(4'd0) || seg_l !== ~font(4'd0)
          || dp_h !== 1'b0 || dp_l !== 1'b1) begin
         bad++;
         $display("FAIL reset_seg got=%h/%h dp=%b/%b want=%h", seg_h, seg_l,
                  dp_h, dp_l, font(4'd0));
      end
      shown = RST_PAT;
   endtask

   task automatic test_scan();
      int ix;
      logic [5:0] ea;
      for (int k = 0; k < 36; k++) begin
         ix = (6 - (k / DIV) % 6) % 6;
         ea = 6'(1 << ix);
         total++;
         if (an_h !== ea || an_l !== ~ea || dp_h !== (ix == 2)
             || dp_l !== (ix != 2) || seg_h !== font(RST_PAT[ix])) begin
            bad++;
            $display("FAIL scan k=%0d an=%b/%b dp=%b seg=%h want an=%b seg=%h",
                     k, an_h, an_l, dp_h, seg_h, ea, font(RST_PAT[ix]));
         end
         step();
      end
   endtask

   task automatic test_convert();
      logic [7:0] d_acc [10] = '{8'h80, 8'd127, 8'd0, 8'd7, 8'd0,
                                8'hFF, 8'd100, 8'd10, 8'd55, 8'hC0};
      int d_frac [10] = '{5, 99, 0, 50, 120, 0, 1, 9, 33, 99};
      bit d_err [10]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      logic [7:0] a;
      int f, s, expb;
      bit e;
      logic [5:0][3:0] eg;
      logic [5:0] edp;
      for (int v = 0; v < 30; v++) begin
         if (v < 10) begin
            a = d_acc[v]; f = d_frac[v]; e = d_err[v];
         end else begin
            a = 8'($urandom_range(255));
            f = $urandom_range(127);
            e = ($urandom_range(7) == 0);
         end
         eg   = model(a, f, e);
         edp  = e ? 6'b000000 : 6'b000100;
         expb = e ? 1 : 16;
         run_load(a, f, e);
         total++;
         if (nh !== expb || nl !== expb) begin
            bad++;
            $display("FAIL busy_len v=%0d got=%0d/%0d want=%0d", v, nh, nl, expb);
         end
         s = slot(o16_an);
         total++;
         if (s < 0 || o16_seg !== font(shown[s])) begin
            bad++;
            $display("FAIL hold_old v=%0d an=%b seg=%h", v, o16_an, o16_seg);
         end
         s = slot(o17_an);
         total++;
         if (s < 0 || o17_seg !== font(eg[s]) || o17_dp !== (s == 2 && !e)) begin
            bad++;
            $display("FAIL visible_new v=%0d an=%b seg=%h dp=%b", v, o17_an,
                     o17_seg, o17_dp);
         end
         read_display();
         total++;
         if (obs_seg_h !== segs(eg) || obs_seg_l !== ~segs(eg)) begin
            bad++;
            $display("FAIL digits v=%0d acc=%h frac=%0d err=%b got=%h/%h want=%h",
                     v, a, f, e, obs_seg_h, obs_seg_l, segs(eg));
         end
         total++;
         if (obs_dp_h !== edp || obs_dp_l !== ~edp) begin
            bad++;
            $display("FAIL dp v=%0d got=%b/%b want=%b", v, obs_dp_h, obs_dp_l, edp);
         end
         total++;
         if (seen_h !== 6'h3F || seen_l !== 6'h3F || !an_ok) begin
            bad++;
            $display("FAIL scan_cover v=%0d seen=%b/%b", v, seen_h, seen_l);
         end
         shown = eg;
      end
   endtask

   task automatic test_pending();
      logic [5:0][3:0] p5, pf;
      bit eb;
      int s;
      p5 = model(8'd5, 0, 1'b0);
      pf = model(8'hFD, 0, 1'b0);
      frac_q = 7'd0; frac_err = 1'b0;
      for (int c = 0; c <= 40; c++) begin
         load = 1'b0;
         if (c == 0)  begin acc_int = 8'd5;  load = 1'b1; end
         if (c == 4)  begin acc_int = 8'd9;  load = 1'b1; end
         if (c == 10) begin acc_int = 8'hFD; load = 1'b1; end
         if (c > 0) begin
            eb = (c >= 1 && c <= 16) || (c >= 18 && c <= 33);
            total++;
            if (busy_h !== eb || busy_l !== eb) begin
               bad++;
               $display("FAIL pend_busy c=%0d got=%b/%b want=%b", c, busy_h,
                        busy_l, eb);
            end
         end
         if (c >= 17 && c <= 33) begin
            s = slot(an_h);
            total++;
            if (s < 0 || seg_h !== font(p5[s])) begin
               bad++;
               $display("FAIL pend_first c=%0d an=%b seg=%h", c, an_h, seg_h);
            end
         end
         step();
      end
      load = 1'b0;
      read_display();
      total++;
      if (obs_seg_h !== segs(pf) || obs_seg_l !== ~segs(pf)) begin
         bad++;
         $display("FAIL pend_last got=%h want=%h", obs_seg_h, segs(pf));
      end
      shown = pf;
   endtask

   task automatic test_commit_load();
      logic [5:0][3:0] pb;
      bit eb;
      pb = model(8'h9D, 1, 1'b0);
      frac_err = 1'b0;
      for (int c = 0; c <= 36; c++) begin
         load = 1'b0;
         if (c == 0)  begin acc_int = 8'd42;  frac_q = 7'd10; load = 1'b1; end
         if (c == 16) begin acc_int = 8'h9D;  frac_q = 7'd1;  load = 1'b1; end
         if (c > 0) begin
            eb = (c >= 1 && c <= 16) || (c >= 18 && c <= 33);
            total++;
            if (busy_h !== eb || busy_l !== eb) begin
               bad++;
               $display("FAIL commit_load_busy c=%0d got=%b/%b want=%b", c,
                        busy_h, busy_l, eb);
            end
         end
         step();
      end
      read_display();
      total++;
      if (obs_seg_h !== segs(pb) || obs_seg_l !== ~segs(pb)) begin
         bad++;
         $display("FAIL commit_load_digits got=%h want=%h", obs_seg_h, segs(pb));
      end
      shown = pb;
   endtask

   task automatic test_reset_mid();
      frac_err = 1'b0;
      for (int c = 0; c <= 30; c++) begin
         load = 1'b0;
         rst  = 1'b0;
         if (c == 0) begin acc_int = 8'd77; frac_q = 7'd25; load = 1'b1; end
         if (c == 3) begin acc_int = 8'd33; frac_q = 7'd44; load = 1'b1; end
         if (c == 8) rst = 1'b1;
         if (c == 9) begin
            total++;
            if (an_h !== 6'b000001 || an_l !== 6'b111110) begin
               bad++;
               $display("FAIL rst_mid_an got=%b/%b want=000001", an_h, an_l);
            end
         end
         if (c >= 9) begin
            total++;
            if (busy_h !== 1'b0 || busy_l !== 1'b0) begin
               bad++;
               $display("FAIL rst_mid_busy c=%0d got=%b/%b want=0", c, busy_h,
                        busy_l);
            end
         end
         step();
      end
      rst = 1'b0;
      read_display();
      total++;
      if (obs_seg_h !== segs(RST_PAT) || obs_seg_l !== ~segs(RST_PAT)
          || obs_dp_h !== 6'b000100) begin
         bad++;
         $display("FAIL rst_mid_digits got=%h want=%h", obs_seg_h,
                  segs(RST_PAT));
      end
      shown = RST_PAT;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; load = 1'b0; acc_int = '0; frac_q = '0; frac_err = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      test_reset();
      test_scan();
      test_convert();
      test_pending();
      test_commit_load();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
